cursor_engine: RTL and testbench
================================

CURSOR_ENGINE -- requirements
Module: cursor_engine

Interface
REQ-001 Parameters (name, default, meaning): ROWS, 24, screen rows; COLS, 80, screen columns; W, 8, coordinate/parameter width; ROWS and COLS SHALL each be <= 2**W - 1.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous, active-high reset.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, engine accepts a command.
- cmd_op, in, 5, opcode: 0 NOP, 1 CUP, 2 CUF, 3 CUB, 4 CUD, 5 CUU, 6 IND, 7 RI, 8 NEL, 9 LF, 10 CR, 11 BS, 12 HT, 13 HTS, 14 TBC, 15 PRINT, 16 DECSC, 17 DECRC, others NOP.
- cmd_p1, in, W, first numeric parameter.
- cmd_p2, in, W, second numeric parameter.
- origin_mode, in, 1, terminal mode flag.
- auto_wrap, in, 1, terminal mode flag.
- line_feed, in, 1, terminal mode flag.
- scroll_top, in, W, scroll region top row; scroll_top <= scroll_bottom < ROWS.
- scroll_bottom, in, W, scroll region bottom row.
- cur_row, out, W, registered absolute cursor row.
- cur_col, out, W, registered absolute cursor column.
- scroll_valid, out, 1, scroll request pending.
- scroll_ready, in, 1, scroll consumer accepts.
- scroll_dir, out, 1, 0 = up (content moves up), 1 = down.
- scroll_lines, out, W, lines to scroll.

Function
REQ-003 Command transfers on a clk edge with cmd_valid && cmd_ready; cmd_ready SHALL be 1 only in state IDLE.
REQ-004 FSM states: IDLE, TAB_SCAN, SCROLL_WAIT; all non-HT, non-scrolling commands SHALL update cur_row/cur_col in the cycle after acceptance and stay in IDLE.
REQ-005 Pn = max(cmd_p1, 1); all arithmetic SHALL be evaluated at W+1 bits and clamped, never wrapping.
REQ-006 CUP: row = p1 ? p1 - 1 : 0; col = p2 ? p2 - 1 : 0.
- origin_mode = 1: cur_row = scroll_top + min(row, scroll_bottom - scroll_top).
- origin_mode = 0: cur_row = min(row, ROWS - 1).
- cur_col = min(col, COLS - 1).
REQ-007 CUF/CUB: cur_col +/- Pn, clamped to [0, COLS - 1].
REQ-008 CUD: cur_row + Pn, clamped to scroll_bottom if cur_row <= scroll_bottom, else to ROWS - 1.
REQ-009 CUU: cur_row - Pn, clamped to scroll_top if cur_row >= scroll_top, else to 0.
REQ-010 IND/LF: cur_row = scroll_bottom -> row unchanged, issue scroll up 1; else cur_row + 1, clamped to ROWS - 1. LF also sets cur_col = 0 when line_feed = 1. NEL behaves as IND plus cur_col = 0.
REQ-011 RI: cur_row = scroll_top -> row unchanged, issue scroll down 1; else cur_row - 1, floored at 0.
REQ-012 CR: cur_col = 0. BS: cur_col - 1, floored at 0.
REQ-013 PRINT: cur_col < COLS - 1 -> cur_col + 1. At COLS - 1 with auto_wrap = 1 -> NEL semantics. At COLS - 1 with auto_wrap = 0 -> no change.
REQ-014 Issuing a scroll: assert scroll_valid with scroll_dir and scroll_lines = 1 and enter SCROLL_WAIT; outputs SHALL hold stable until scroll_ready is sampled high, then return to IDLE the following cycle. Cursor update occurs on acceptance, not on scroll completion.
REQ-015 HTS sets the tab stop at cur_col. TBC with p1 = 0 clears the stop at cur_col; p1 = 3 clears all stops; other p1 values are ignored.
REQ-016 DECSC stores cur_row and cur_col. DECRC restores them; DECRC before any DECSC restores (0,0).

Reset
REQ-017 On rst: cur_row = 0, cur_col = 0, state IDLE, scroll_valid = 0, scroll_dir = 0, scroll_lines = 0, saved cursor (0,0). cmd_ready = 1 after release; tab stops reset to columns 8, 16, 24, ... < COLS.
REQ-018 rst asserted in TAB_SCAN or SCROLL_WAIT SHALL abort the operation immediately with no partial cursor update.

Configuration
REQ-019 Macro CURSOR_ENGINE_TAB_STOPS_EN defined: COLS-bit tab-stop register implemented.
- HT enters TAB_SCAN and tests one column per cycle from cur_col + 1.
- Stops at the first set stop or at COLS - 1; writes cur_col and returns to IDLE.
- Latency = columns scanned + 1.
REQ-020 Macro undefined: no tab-stop register. HT completes in one cycle: cur_col = min((cur_col | 7) + 1, COLS - 1). HTS and TBC are NOP.

Verification
REQ-021 Reset, then CUP p1 = 5, p2 = 10 -> cur_row = 4, cur_col = 9 one cycle later.
REQ-022 scroll_top = 2, scroll_bottom = 10, origin_mode = 1, CUP p1 = 30 -> cur_row = 10. CUD Pn = 50 from row 3 -> row 10.
REQ-023 cur_row = 10 = scroll_bottom, IND with scroll_ready held 0 for 5 cycles -> scroll_valid high with dir 0, lines 1, for all 5 cycles; cmd_ready low until one cycle after scroll_ready.
REQ-024 Tab stops enabled: TBC p1 = 3, HTS at col 20, col = 3, HT -> cur_col = 20 after 18 cycles. Macro off: col 3 -> 8; col 79 -> 79.
REQ-025 auto_wrap = 1, cur_col = 79, cur_row = scroll_bottom, PRINT -> cur_col = 0, scroll up 1. auto_wrap = 0 -> no change.
REQ-026 DECSC at (7,33), CUP 1;1, DECRC -> (7,33). rst during TAB_SCAN -> (0,0), IDLE, default tab stops.

Source files
------------

// File: rtl/cursor_engine.sv
// cursor_engine: terminal cursor positioning with scroll-region handling and scroll requests.
// Define CURSOR_ENGINE_TAB_STOPS_EN for a per-column tab-stop register with a serial HT scan.
module cursor_engine #(
  parameter int ROWS = 24,
  parameter int COLS = 80,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [4:0]   cmd_op,
  input  logic [W-1:0] cmd_p1,
  input  logic [W-1:0] cmd_p2,
  input  logic         origin_mode,
  input  logic         auto_wrap,
  input  logic         line_feed,
  input  logic [W-1:0] scroll_top,
  input  logic [W-1:0] scroll_bottom,
  output logic [W-1:0] cur_row,
  output logic [W-1:0] cur_col,
  output logic         scroll_valid,
  input  logic         scroll_ready,
  output logic         scroll_dir,
  output logic [W-1:0] scroll_lines
);
  localparam logic [4:0] OP_CUP = 5'd1, OP_CUF = 5'd2, OP_CUB = 5'd3, OP_CUD = 5'd4, OP_CUU = 5'd5;
  localparam logic [4:0] OP_IND = 5'd6, OP_RI = 5'd7, OP_NEL = 5'd8, OP_LF = 5'd9, OP_CR = 5'd10;
  localparam logic [4:0] OP_BS = 5'd11, OP_HT = 5'd12, OP_HTS = 5'd13, OP_TBC = 5'd14;
  localparam logic [4:0] OP_PRINT = 5'd15, OP_DECSC = 5'd16, OP_DECRC = 5'd17;
  localparam logic [W:0] ONE     = (W+1)'(1);
  localparam logic [W:0] SEVEN   = (W+1)'(7);
  localparam logic [W:0] ROW_MAX = (W+1)'(ROWS - 1);
  localparam logic [W:0] COL_MAX = (W+1)'(COLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_TAB_SCAN, S_SCROLL_WAIT} state_t;
  state_t r_state, w_state_next;

  logic [W-1:0] r_row, r_col, r_save_row, r_save_col, r_scroll_lines;
  logic         r_scroll_valid, r_scroll_dir;
  logic         w_accept, w_at_top, w_at_bot, w_scroll, w_scroll_dn;
  logic [W:0]   w_row, w_col, w_top, w_bot, w_pn, w_p1m, w_p2m;
  logic [W-1:0] w_idx_row, w_ri_row, w_cup_row, w_cud_row, w_cuu_row, w_col_step;
  logic [W-1:0] w_row_next, w_col_next;

  // Saturating helpers: inputs are W+1 bits wide, results always fit W bits.
  function automatic logic [W-1:0] f_min(input logic [W:0] a, input logic [W:0] b);
    return (a < b) ? a[W-1:0] : b[W-1:0];
  endfunction
  function automatic logic [W-1:0] f_max(input logic [W:0] a, input logic [W:0] b);
    return (a > b) ? a[W-1:0] : b[W-1:0];
  endfunction

  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign w_row      = {1'b0, r_row};
  assign w_col      = {1'b0, r_col};
  assign w_top      = {1'b0, scroll_top};
  assign w_bot      = {1'b0, scroll_bottom};
  assign w_pn       = (cmd_p1 == '0) ? ONE : {1'b0, cmd_p1};
  assign w_p1m      = (cmd_p1 == '0) ? '0 : {1'b0, cmd_p1} - ONE;
  assign w_p2m      = (cmd_p2 == '0) ? '0 : {1'b0, cmd_p2} - ONE;
  assign w_at_top   = (r_row == scroll_top);
  assign w_at_bot   = (r_row == scroll_bottom);
  assign w_idx_row  = w_at_bot ? r_row : f_min(w_row + ONE, ROW_MAX);
  assign w_ri_row   = (w_at_top || r_row == '0) ? r_row : r_row - W'(1);
  assign w_cup_row  = origin_mode ? scroll_top + f_min(w_p1m, w_bot - w_top) : f_min(w_p1m, ROW_MAX);
  assign w_cud_row  = f_min(w_row + w_pn, (w_row <= w_bot) ? w_bot : ROW_MAX);
  assign w_cuu_row  = f_max((w_row >= w_pn) ? w_row - w_pn : '0, (w_row >= w_top) ? w_top : '0);
  assign w_col_step = f_min(w_col + ONE, COL_MAX);

  always_comb begin
    w_row_next  = r_row;
    w_col_next  = r_col;
    w_scroll    = 1'b0;
    w_scroll_dn = 1'b0;
    case (cmd_op)
      OP_CUP: begin
        w_row_next = w_cup_row;
        w_col_next = f_min(w_p2m, COL_MAX);
      end
      OP_CUF: w_col_next = f_min(w_col + w_pn, COL_MAX);
      OP_CUB: w_col_next = f_min((w_col >= w_pn) ? w_col - w_pn : '0, COL_MAX);
      OP_CUD: w_row_next = w_cud_row;
      OP_CUU: w_row_next = w_cuu_row;
      OP_IND: begin
        w_row_next = w_idx_row;
        w_scroll   = w_at_bot;
      end
      OP_NEL: begin
        w_row_next = w_idx_row;
        w_col_next = '0;
        w_scroll   = w_at_bot;
      end
      OP_LF: begin
        w_row_next = w_idx_row;
        w_scroll   = w_at_bot;
        if (line_feed) w_col_next = '0;
      end
      OP_RI: begin
        w_row_next  = w_ri_row;
        w_scroll    = w_at_top;
        w_scroll_dn = w_at_top;
      end
      OP_CR: w_col_next = '0;
      OP_BS: w_col_next = (r_col == '0) ? '0 : r_col - W'(1);
`ifndef CURSOR_ENGINE_TAB_STOPS_EN
      OP_HT: w_col_next = f_min((w_col | SEVEN) + ONE, COL_MAX);
`endif
      OP_PRINT: begin
        if (w_col < COL_MAX) begin
          w_col_next = w_col_step;
        end else if (auto_wrap) begin
          w_row_next = w_idx_row;
          w_col_next = '0;
          w_scroll   = w_at_bot;
        end
      end
      OP_DECRC: begin
        w_row_next = r_save_row;
        w_col_next = r_save_col;
      end
      default: ;
    endcase
  end

`ifdef CURSOR_ENGINE_TAB_STOPS_EN
  function automatic logic [COLS-1:0] f_tab_init();
    for (int i = 0; i < COLS; i++) f_tab_init[i] = (i != 0) && (i % 8 == 0);
  endfunction
  localparam logic [COLS-1:0] TAB_INIT = f_tab_init();

  logic [COLS-1:0] r_tabs, w_tab_next, w_hit;
  logic [W-1:0]    r_scan;
  logic            w_ht, w_tab_set, w_tab_clr_one, w_tab_clr_all, w_scan_done;

  assign w_ht          = w_accept && (cmd_op == OP_HT);
  assign w_tab_set     = w_accept && (cmd_op == OP_HTS);
  assign w_tab_clr_one = w_accept && (cmd_op == OP_TBC) && (cmd_p1 == '0);
  assign w_tab_clr_all = w_accept && (cmd_op == OP_TBC) && (cmd_p1 == W'(3));

  for (genvar gi = 0; gi < COLS; gi++) begin : g_tab
    assign w_tab_next[gi] = w_tab_clr_all ? 1'b0 :
                            (r_col != W'(gi)) ? r_tabs[gi] :
                            w_tab_set ? 1'b1 : w_tab_clr_one ? 1'b0 : r_tabs[gi];
    assign w_hit[gi] = r_tabs[gi] && (r_scan == W'(gi));
  end
  assign w_scan_done = (|w_hit) || ({1'b0, r_scan} >= COL_MAX);

  // r_scan holds the column under test; it starts one past the cursor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tabs <= TAB_INIT;
      r_scan <= '0;
    end else begin
      r_tabs <= w_tab_next;
      if (w_ht) r_scan <= w_col_step;
      else if (r_state == S_TAB_SCAN && !w_scan_done) r_scan <= r_scan + W'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_scroll) w_state_next = S_SCROLL_WAIT;
`ifdef CURSOR_ENGINE_TAB_STOPS_EN
        else if (w_ht) w_state_next = S_TAB_SCAN;
`endif
      end
      S_TAB_SCAN: begin
`ifdef CURSOR_ENGINE_TAB_STOPS_EN
        if (w_scan_done) w_state_next = S_IDLE;
`else
        w_state_next = S_IDLE;
`endif
      end
      S_SCROLL_WAIT: if (scroll_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row          <= '0;
      r_col          <= '0;
      r_save_row     <= '0;
      r_save_col     <= '0;
      r_scroll_valid <= 1'b0;
      r_scroll_dir   <= 1'b0;
      r_scroll_lines <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_row <= w_row_next;
            r_col <= w_col_next;
            if (cmd_op == OP_DECSC) begin
              r_save_row <= r_row;
              r_save_col <= r_col;
            end
            if (w_scroll) begin
              r_scroll_valid <= 1'b1;
              r_scroll_dir   <= w_scroll_dn;
              r_scroll_lines <= W'(1);
            end
          end
        end
        S_TAB_SCAN: begin
`ifdef CURSOR_ENGINE_TAB_STOPS_EN
          if (w_scan_done) r_col <= r_scan;
`endif
        end
        S_SCROLL_WAIT: if (scroll_ready) r_scroll_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign cur_row      = r_row;
  assign cur_col      = r_col;
  assign scroll_valid = r_scroll_valid;
  assign scroll_dir   = r_scroll_dir;
  assign scroll_lines = r_scroll_lines;
endmodule

// File: tb/tb_cursor_engine.sv
// Directed bench for cursor_engine (default 24x80, W=8) with hand-computed expectations.
module tb_cursor_engine;
  localparam logic [4:0] NOP = 0, CUP = 1, CUF = 2, CUB = 3, CUD = 4, CUU = 5, IND = 6, RI = 7;
  localparam logic [4:0] NEL = 8, LF = 9, CR = 10, BS = 11, HT = 12, HTS = 13, TBC = 14;
  localparam logic [4:0] PRINT = 15, DECSC = 16, DECRC = 17;

  logic       clk = 0, rst = 1, cmd_valid = 0, cmd_ready;
  logic [4:0] cmd_op = 0;
  logic [7:0] cmd_p1 = 0, cmd_p2 = 0, scroll_top = 0, scroll_bottom = 23;
  logic       origin_mode = 0, auto_wrap = 0, line_feed = 0, scroll_ready = 1;
  logic [7:0] cur_row, cur_col, scroll_lines;
  logic       scroll_valid, scroll_dir;
  int tests = 0, fails = 0, cyc;

  cursor_engine #(.ROWS(24), .COLS(80), .W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_p1(cmd_p1), .cmd_p2(cmd_p2), .origin_mode(origin_mode), .auto_wrap(auto_wrap),
    .line_feed(line_feed), .scroll_top(scroll_top), .scroll_bottom(scroll_bottom),
    .cur_row(cur_row), .cur_col(cur_col), .scroll_valid(scroll_valid),
    .scroll_ready(scroll_ready), .scroll_dir(scroll_dir), .scroll_lines(scroll_lines));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("[TB] check %s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic pos(input string tag, input int row, input int col);
    chk({tag, ".row"}, 32'(cur_row), 32'(row));
    chk({tag, ".col"}, 32'(cur_col), 32'(col));
  endtask

  // Waits (bounded) for cmd_ready, offers one command for one edge, returns 1 time unit later.
  task automatic send(input logic [4:0] op, input logic [7:0] p1, input logic [7:0] p2);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    chk("ready_before_cmd", 32'(cmd_ready), 1);
    cmd_op = op; cmd_p1 = p1; cmd_p2 = p2; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_op = NOP;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 1;
    while (!cmd_ready && cycles < 300) begin @(posedge clk); #1; cycles++; end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    pos("reset", 0, 0);
    chk("reset.scroll_valid", 32'(scroll_valid), 0);
    chk("reset.scroll_dir", 32'(scroll_dir), 0);
    chk("reset.scroll_lines", 32'(scroll_lines), 0);
    @(negedge clk); rst = 0;
    #1 chk("reset.cmd_ready", 32'(cmd_ready), 1);

    send(CUP, 5, 10);   pos("cup_5_10", 4, 9);
    send(DECRC, 0, 0);  pos("decrc_no_save", 0, 0);
    send(CUP, 5, 10);   send(CUF, 0, 0);  pos("cuf_p0", 4, 10);
    send(CUF, 200, 0);  pos("cuf_clamp", 4, 79);
    send(CUB, 5, 0);    pos("cub_5", 4, 74);
    send(CUB, 250, 0);  pos("cub_clamp", 4, 0);
    send(CUP, 0, 0);    pos("cup_0_0", 0, 0);
    send(CUP, 200, 200); pos("cup_clamp", 23, 79);
    send(NOP, 5, 5);    pos("nop", 23, 79);
    send(5'd31, 5, 5);  pos("undef_op", 23, 79);

    // Scroll region 2..10 with origin mode
    scroll_top = 2; scroll_bottom = 10; origin_mode = 1;
    send(CUP, 30, 1);   pos("cup_origin_clamp", 10, 0);
    send(CUP, 2, 1);    pos("cup_origin_2", 3, 0);
    send(CUD, 50, 0);   pos("cud_to_bottom", 10, 0);
    scroll_ready = 0;
    send(IND, 0, 0);
    pos("ind_bottom", 10, 0);
    chk("ind.cmd_ready", 32'(cmd_ready), 0);
    for (int i = 0; i < 5; i++) begin
      chk("ind.scroll_valid", 32'(scroll_valid), 1);
      chk("ind.scroll_dir", 32'(scroll_dir), 0);
      chk("ind.scroll_lines", 32'(scroll_lines), 1);
      if (i < 4) begin @(posedge clk); #1; end
    end
    @(negedge clk); scroll_ready = 1;
    chk("ind.ready_still_low", 32'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("ind.valid_cleared", 32'(scroll_valid), 0);
    chk("ind.ready_back", 32'(cmd_ready), 1);
    send(CUU, 50, 0);   pos("cuu_to_top", 2, 0);
    send(RI, 0, 0);
    pos("ri_top", 2, 0);
    chk("ri.scroll_valid", 32'(scroll_valid), 1);
    chk("ri.scroll_dir", 32'(scroll_dir), 1);
    @(posedge clk); #1;
    chk("ri.valid_cleared", 32'(scroll_valid), 0);
    send(CUP, 2, 1);    send(RI, 0, 0);  pos("ri_mid", 2, 0);
    chk("ri_mid.no_scroll", 32'(scroll_valid), 0);

    // Full screen, line controls
    origin_mode = 0; scroll_top = 0; scroll_bottom = 23;
    send(CUP, 6, 20);   pos("cup_6_20", 5, 19);
    send(LF, 0, 0);     pos("lf_nolfmode", 6, 19);
    line_feed = 1;
    send(LF, 0, 0);     pos("lf_lfmode", 7, 0);
    send(NEL, 0, 0);    pos("nel", 8, 0);
    send(CUF, 5, 0);    send(BS, 0, 0);  pos("bs", 8, 4);
    send(CR, 0, 0);     pos("cr", 8, 0);
    send(BS, 0, 0);     pos("bs_floor", 8, 0);
    send(CUP, 8, 34);   send(DECSC, 0, 0);
    send(CUP, 1, 1);    pos("cup_home", 0, 0);
    send(DECRC, 0, 0);  pos("decrc", 7, 33);

    // PRINT and wrap
    send(CUP, 1, 79);   send(PRINT, 0, 0); pos("print_adv", 0, 79);
    send(PRINT, 0, 0);  pos("print_nowrap", 0, 79);
    chk("print_nowrap.no_scroll", 32'(scroll_valid), 0);
    scroll_bottom = 10; auto_wrap = 1;
    send(CUP, 11, 80);  send(PRINT, 0, 0); pos("print_wrap", 10, 0);
    chk("print_wrap.scroll_valid", 32'(scroll_valid), 1);
    chk("print_wrap.scroll_dir", 32'(scroll_dir), 0);

    // Cursor outside the region
    send(CUP, 16, 1);   send(CUD, 50, 0); pos("cud_below_region", 23, 0);
    send(IND, 0, 0);    pos("ind_last_row", 23, 0);
    chk("ind_last_row.no_scroll", 32'(scroll_valid), 0);
    scroll_top = 4;
    send(CUP, 3, 1);    send(CUU, 50, 0); pos("cuu_above_region", 0, 0);

`ifdef CURSOR_ENGINE_TAB_STOPS_EN
    send(CUP, 1, 4);    send(HT, 0, 0);  wait_idle(cyc);
    chk("ht_default.latency", 32'(cyc), 6);  pos("ht_default", 0, 8);
    send(TBC, 3, 0);    send(CUP, 1, 21); send(HTS, 0, 0);
    send(CUP, 1, 4);    send(HT, 0, 0);  wait_idle(cyc);
    chk("ht_20.latency", 32'(cyc), 18);      pos("ht_20", 0, 20);
    send(TBC, 0, 0);    send(CUP, 1, 4); send(HT, 0, 0); wait_idle(cyc);
    chk("ht_none.latency", 32'(cyc), 77);    pos("ht_none", 0, 79);
    send(CUP, 1, 4);    send(HT, 0, 0);
    repeat (3) @(posedge clk);
    #1 pos("ht_scan_midway", 0, 3);
    chk("ht_scan.ready_low", 32'(cmd_ready), 0);
    rst = 1;
    #1 pos("rst_in_scan", 0, 0);
    chk("rst_in_scan.ready", 32'(cmd_ready), 1);
    @(negedge clk); rst = 0;
    send(HT, 0, 0);     wait_idle(cyc);
    chk("ht_after_rst.latency", 32'(cyc), 9); pos("ht_after_rst", 0, 8);
`else
    send(CUP, 1, 4);    send(HT, 0, 0);  pos("ht_3", 0, 8);
    chk("ht_3.ready", 32'(cmd_ready), 1);
    send(CUP, 1, 76);   send(HT, 0, 0);  pos("ht_75", 0, 79);
    send(HT, 0, 0);     pos("ht_79", 0, 79);
    send(CUP, 1, 4);    send(HTS, 0, 0); send(TBC, 3, 0); send(HT, 0, 0);
    pos("hts_tbc_nop", 0, 8);
`endif

    // Reset while waiting on a scroll
    scroll_top = 0; scroll_bottom = 10; scroll_ready = 0;
    send(CUP, 11, 5);   send(IND, 0, 0);
    chk("scroll_wait.valid", 32'(scroll_valid), 1);
    @(posedge clk); #1;
    rst = 1;
    #1 pos("rst_in_scroll", 0, 0);
    chk("rst_in_scroll.valid", 32'(scroll_valid), 0);
    chk("rst_in_scroll.lines", 32'(scroll_lines), 0);
    chk("rst_in_scroll.ready", 32'(cmd_ready), 1);
    @(negedge clk); rst = 0; scroll_ready = 1;
    send(CUP, 3, 3);    pos("after_rst", 2, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
